lfsr_seq: RTL and testbench

Sequencer for an XNOR-feedback Fibonacci LFSR. It loads a software seed, then streams a programmed number of pseudo-random words over a valid/ready interface, advancing the LFSR exactly once per accepted word. It also guards against the all-ones lock-up state. It sits between a register/config block and any PRBS consumer (pattern generator, scrambler, test traffic source).

---
 rtl/lfsr_seq_pkg.sv | 59 +++++
 rtl/lfsr_seq_core.sv | 43 ++++
 rtl/lfsr_seq.sv | 116 +++++++++++
 tb/tb_lfsr_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_seq_pkg.sv
// Shared types and tap table for the XNOR Fibonacci LFSR sequencer.
package lfsr_seq_pkg;

  localparam int MIN_N = 3;
  localparam int MAX_N = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  function automatic logic [MAX_N-1:0] tap_bit(input int k);
    logic [MAX_N-1:0] one;
    one = 1;
    return one << (k - 1);
  endfunction

  // Maximal-length XNOR taps, listed 1-based as in XAPP052.
  function automatic logic [MAX_N-1:0] lfsr_taps(input int n);
    logic [MAX_N-1:0] m;
    m = '0;
    case (n)
      3:  m = tap_bit(3)  | tap_bit(2);
      4:  m = tap_bit(4)  | tap_bit(3);
      5:  m = tap_bit(5)  | tap_bit(3);
      6:  m = tap_bit(6)  | tap_bit(5);
      7:  m = tap_bit(7)  | tap_bit(6);
      8:  m = tap_bit(8)  | tap_bit(6)  | tap_bit(5)  | tap_bit(4);
      9:  m = tap_bit(9)  | tap_bit(5);
      10: m = tap_bit(10) | tap_bit(7);
      11: m = tap_bit(11) | tap_bit(9);
      12: m = tap_bit(12) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
      13: m = tap_bit(13) | tap_bit(4)  | tap_bit(3)  | tap_bit(1);
      14: m = tap_bit(14) | tap_bit(5)  | tap_bit(3)  | tap_bit(1);
      15: m = tap_bit(15) | tap_bit(14);
      16: m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
      17: m = tap_bit(17) | tap_bit(14);
      18: m = tap_bit(18) | tap_bit(11);
      19: m = tap_bit(19) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
      20: m = tap_bit(20) | tap_bit(17);
      21: m = tap_bit(21) | tap_bit(19);
      22: m = tap_bit(22) | tap_bit(21);
      23: m = tap_bit(23) | tap_bit(18);
      24: m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
      25: m = tap_bit(25) | tap_bit(22);
      26: m = tap_bit(26) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
      27: m = tap_bit(27) | tap_bit(5)  | tap_bit(2)  | tap_bit(1);
      28: m = tap_bit(28) | tap_bit(25);
      29: m = tap_bit(29) | tap_bit(27);
      30: m = tap_bit(30) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
      31: m = tap_bit(31) | tap_bit(28);
      32: m = tap_bit(32) | tap_bit(22) | tap_bit(2)  | tap_bit(1);
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr_seq_core.sv
// LFSR register with XNOR feedback; a load takes priority over a step.
module lfsr_core
  import lfsr_seq_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [N-1:0] seed_i,
  input  logic         step_i,
  output logic [N-1:0] state_o
);

  localparam logic [MAX_N-1:0] TAPS_FULL = lfsr_taps(N);
  localparam logic [N-1:0]     TAPS      = TAPS_FULL[N-1:0];

  logic [N-1:0] state_q;
  logic [N-1:0] state_d;
  logic         fb;

  assign fb = ~^(state_q & TAPS);

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (step_i) begin
      state_d = {state_q[N-2:0], fb};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/lfsr_seq.sv
// Burst sequencer: seed load, counted valid/ready stream, abort and lock-up guard.
module lfsr_seq
  import lfsr_seq_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     cfg_seed_i,
  input  logic [CNT_W-1:0] cfg_len_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             lockup_o,
  output logic [N-1:0]     data_o,
  output logic             valid_o,
  input  logic             ready_i
);

  generate
    if (N < MIN_N || N > MAX_N) begin : g_bad_n
      $error("lfsr_seq: N must be within 3..32");
    end
  endgenerate

  state_e           state_q;
  logic [N-1:0]     seed_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             lockup_q;
  logic             valid_q;

  logic             xfer;
  logic             last_xfer;
  logic             core_load;
  logic [N-1:0]     core_seed;

  assign xfer      = valid_q & ready_i;
  assign last_xfer = xfer && (cnt_q == CNT_W'(1));
  assign core_load = (state_q == LOAD);
  // lockup_q is already valid in LOAD, so it doubles as the substitution select.
  assign core_seed = lockup_q ? '0 : seed_q;

  lfsr_core #(.N(N)) u_core (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (core_load),
    .seed_i  (core_seed),
    .step_i  (xfer),
    .state_o (data_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      seed_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lockup_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i && (cfg_len_i != '0)) begin
            seed_q   <= cfg_seed_i;
            cnt_q    <= cfg_len_i;
            lockup_q <= &cfg_seed_i;
            busy_q   <= 1'b1;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          if (stop_i) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            valid_q <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
          // Completion outranks an abort landing on the final word.
          if (last_xfer) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (stop_i) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign lockup_o = lockup_q;
  assign valid_o  = valid_q;

endmodule

// File: tb/tb_lfsr_seq.sv
// Drives N=4, N=8 and N=32 sequencers in lockstep against a word-list reference model.
module tb_lfsr_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, ready;
  logic [31:0] cfg_seed;
  logic [7:0]  cfg_len;
  logic [2:0]  busy, done, lockup, valid;
  logic [3:0]  d4;
  logic [7:0]  d8;
  logic [31:0] d32;

  int checks = 0;
  int errors = 0;
  int nsz [3] = '{4, 8, 32};
  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  lfsr_seq #(.N(4), .CNT_W(8)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .cfg_seed_i(cfg_seed[3:0]), .cfg_len_i(cfg_len),
    .start_i(start), .stop_i(stop), .busy_o(busy[0]), .done_o(done[0]),
    .lockup_o(lockup[0]), .data_o(d4), .valid_o(valid[0]), .ready_i(ready));

  lfsr_seq #(.N(8), .CNT_W(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .cfg_seed_i(cfg_seed[7:0]), .cfg_len_i(cfg_len),
    .start_i(start), .stop_i(stop), .busy_o(busy[1]), .done_o(done[1]),
    .lockup_o(lockup[1]), .data_o(d8), .valid_o(valid[1]), .ready_i(ready));

  lfsr_seq #(.N(32), .CNT_W(8)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .cfg_seed_i(cfg_seed), .cfg_len_i(cfg_len),
    .start_i(start), .stop_i(stop), .busy_o(busy[2]), .done_o(done[2]),
    .lockup_o(lockup[2]), .data_o(d32), .valid_o(valid[2]), .ready_i(ready));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dout(input int i);
    case (i)
      0:       return {28'b0, d4};
      1:       return {24'b0, d8};
      default: return d32;
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return m[31:0];
  endfunction

  // Reference step straight from the tap lists (0-based bit numbers).
  function automatic logic [31:0] ref_next(input int n, input logic [31:0] s);
    logic fb;
    case (n)
      4:       fb = ~(s[3] ^ s[2]);
      8:       fb = ~(s[7] ^ s[5] ^ s[4] ^ s[3]);
      default: fb = ~(s[31] ^ s[21] ^ s[1] ^ s[0]);
    endcase
    return ((s << 1) | {31'b0, fb}) & mask_of(n);
  endfunction

  task automatic check_quiet(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_busy_n%0d", tag, nsz[i]), busy[i], 1'b0);
      check($sformatf("%s_valid_n%0d", tag, nsz[i]), valid[i], 1'b0);
      check($sformatf("%s_done_n%0d", tag, nsz[i]), done[i], 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check_quiet("idle");
    end
  endtask

  // mode 0: ready high, 1: random ready plus ignored starts, 2: fixed ready pattern.
  // stop_at >= 0 pulses stop on that transfer; -2 aborts during LOAD.
  task automatic burst(input logic [31:0] seed, input int len, input int mode, input int stop_at);
    logic [31:0] words [3][0:256];
    logic [31:0] s, m;
    bit          lk [3];
    bit          aborted, r;
    int          k, cyc;
    for (int i = 0; i < 3; i++) begin
      m = mask_of(nsz[i]);
      s = seed & m;
      lk[i] = (s == m);
      words[i][0] = lk[i] ? 32'h0 : s;
      for (int j = 1; j <= len; j++) words[i][j] = ref_next(nsz[i], words[i][j-1]);
    end
    cfg_seed = seed;
    cfg_len  = len[7:0];
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("load_busy_n%0d", nsz[i]), busy[i], 1'b1);
      check($sformatf("load_valid_n%0d", nsz[i]), valid[i], 1'b0);
      check($sformatf("load_done_n%0d", nsz[i]), done[i], 1'b0);
      check($sformatf("load_lockup_n%0d", nsz[i]), lockup[i], lk[i]);
    end
    if (stop_at == -2) begin
      stop = 1'b1;
      @(posedge clk);
      @(negedge clk);
      stop = 1'b0;
      check_quiet("load_abort");
      $display("burst seed=%h len=%0d aborted_in_load", seed, len);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    k = 0; cyc = 0; aborted = 0;
    while (1) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("run_valid_n%0d_w%0d", nsz[i], k), valid[i], 1'b1);
        check($sformatf("run_busy_n%0d_w%0d", nsz[i], k), busy[i], 1'b1);
        check($sformatf("run_done_n%0d_w%0d", nsz[i], k), done[i], 1'b0);
        check($sformatf("run_data_n%0d_w%0d", nsz[i], k), dout(i), words[i][k]);
        check($sformatf("run_lockup_n%0d", nsz[i]), lockup[i], lk[i]);
      end
      if (cyc > 4 * len + 20) begin
        check("burst_budget", k, len);
        break;
      end
      r = (mode == 0) ? 1'b1 : (mode == 2) ? pat[cyc % 7] : ($urandom % 3 != 0);
      ready = r;
      stop  = r && (k == stop_at);
      if (mode == 1) begin
        start    = ($urandom % 4 == 0);
        cfg_len  = 8'($urandom_range(1, 255));
        cfg_seed = $urandom;
      end
      @(posedge clk);
      if (r) k++;
      if (stop) aborted = 1;
      cyc++;
      @(negedge clk);
      ready = 1'b0; stop = 1'b0; start = 1'b0;
      if (k == len || aborted) break;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("end_valid_n%0d", nsz[i]), valid[i], 1'b0);
      check($sformatf("end_busy_n%0d", nsz[i]), busy[i], 1'b0);
      check($sformatf("end_done_n%0d", nsz[i]), done[i], (k == len));
      check($sformatf("end_data_n%0d", nsz[i]), dout(i), words[i][k]);
      check($sformatf("end_lockup_n%0d", nsz[i]), lockup[i], lk[i]);
    end
    $display("burst seed=%h len=%0d xfers=%0d cycles=%0d aborted=%0d", seed, len, k, cyc, aborted);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; ready = 1'b0;
    cfg_seed = '0; cfg_len = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_data_n%0d", nsz[i]), dout(i), 32'h0);
      check($sformatf("rst_lockup_n%0d", nsz[i]), lockup[i], 1'b0);
    end
    check_quiet("rst");
    rst = 1'b0;
    idle(1);

    burst(32'h0, 6, 0, -1);
    idle(1);

    burst(32'hFFFF_FFFF, 3, 0, -1);
    burst(32'h1, 3, 0, -1);
    idle(2);

    burst(32'h1, 4, 2, -1);
    idle(1);

    burst($urandom, 10, 1, 3);
    idle(1);

    cfg_len = 8'd0; cfg_seed = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(3);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    idle(2);

    burst($urandom, 5, 1, 4);
    burst($urandom, 7, 0, -2);
    idle(1);

    for (int b = 0; b < 10; b++) begin
      int len;
      len = $urandom_range(1, 20);
      burst($urandom, len, 1, ($urandom % 3 == 0) ? int'($urandom_range(0, len - 1)) : -1);
      if ($urandom % 2 == 0) idle(1);
    end
    idle(1);

    burst($urandom, 255, 0, -1);
    idle(1);

    cfg_seed = $urandom; cfg_len = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ready = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("async_rst_data_n%0d", nsz[i]), dout(i), 32'h0);
      check($sformatf("async_rst_lockup_n%0d", nsz[i]), lockup[i], 1'b0);
    end
    check_quiet("async_rst");
    @(negedge clk);
    rst = 1'b0; ready = 1'b0;
    idle(3);
    @(negedge clk);
    burst(32'h5, 3, 0, -1);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
